// File: rtl/pu_riscv_verilog_pkg.sv
// pu_riscv_verilog_pkg: shared types for the divider arbiter
package pu_riscv_verilog_pkg;
  typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_func_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
endpackage

// File: rtl/pu_riscv_div_core.sv
// pu_riscv_div_core: unsigned restoring shift-subtract divider, one quotient bit per cycle
module pu_riscv_div_core #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] q, r, d;
  logic [XLEN:0] r_sh, diff;
  logic [CW-1:0] cnt;
  logic run, ge;
  assign r_sh = {r, q[XLEN-1]};
  assign diff = r_sh - {1'b0, d};
  assign ge = r_sh >= {1'b0, d};
  // quotient/remainder show the post-step values, so they are final while done is high
  assign quotient = {q[XLEN-2:0], ge};
  assign remainder = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
  assign done = run && cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      q <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      q <= word ? dividend << (XLEN - 32) : dividend;
      r <= '0;
      d <= divisor;
      cnt <= word ? CW'(31) : CW'(XLEN - 1);
    end else if (run) begin
      q <= quotient;
      r <= remainder;
      cnt <= cnt - 1'b1;
      run <= cnt != '0;
    end
  end
endmodule

// File: rtl/pu_riscv_div_arbiter.sv
// pu_riscv_div_arbiter: round-robin sharing of one iterative divider between NREQ requesters
module pu_riscv_div_arbiter
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][XLEN-1:0] req_opA,
  input  logic [NREQ-1:0][XLEN-1:0] req_opB,
  input  logic [NREQ-1:0][1:0]      req_func,
  input  logic [NREQ-1:0]           req_word,
  input  logic [NREQ-1:0]           req_kill,
  input  logic [NREQ-1:0]           rsp_stall,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [XLEN-1:0]           rsp_data,
  output logic                      busy
);
  localparam int PW = $clog2(NREQ);
  div_state_t state;
  div_func_t g_f;
  logic [PW-1:0] rr_ptr, owner, gnt;
  logic gnt_ok, is_rem, word_q, neg_q;
  logic g_w, g_s, g_rem, sa, sb, b0, ovf, special, core_done;
  logic [XLEN-1:0] ea, eb, aa, ab, min_v, sp, core_q, core_r, res;
  function automatic logic [XLEN-1:0] sx32(input logic [XLEN-1:0] v, input logic s);
    return s ? XLEN'($signed(v[31:0])) : XLEN'(v[31:0]);
  endfunction
  always_comb begin
    gnt_ok = 1'b0;
    gnt = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % NREQ] && !req_kill[(int'(rr_ptr) + k) % NREQ]) begin
        gnt_ok = 1'b1;
        gnt = PW'((int'(rr_ptr) + k) % NREQ);
      end
  end
  // operands are widened to XLEN first so word and full-width ops share one sign/abs path
  assign g_f = div_func_t'(req_func[gnt]);
  assign g_w = (XLEN > 32) && req_word[gnt];
  assign g_s = g_f == DIV || g_f == REM;
  assign g_rem = g_f == REM || g_f == REMU;
  assign ea = g_w ? sx32(req_opA[gnt], g_s) : req_opA[gnt];
  assign eb = g_w ? sx32(req_opB[gnt], g_s) : req_opB[gnt];
  assign sa = g_s & ea[XLEN-1];
  assign sb = g_s & eb[XLEN-1];
  assign aa = sa ? -ea : ea;
  assign ab = sb ? -eb : eb;
  assign min_v = g_w ? ~XLEN'(32'h7fff_ffff) : XLEN'(1) << (XLEN - 1);
  assign b0 = eb == '0;
  assign ovf = g_s && ea == min_v && eb == '1;
  assign special = b0 || ovf;
  assign sp = g_rem ? (b0 ? ea : '0) : (b0 ? '1 : ea);
  assign res = is_rem ? core_r : core_q;
  assign req_ready = (state == IDLE && gnt_ok) ? NREQ'(1) << gnt : '0;
  assign rsp_valid = (state == DONE) ? NREQ'(1) << owner : '0;
  assign busy = state != IDLE;
  pu_riscv_div_core #(.XLEN(XLEN)) u_core (
    .clk(clk), .rst(rst), .start(state == IDLE && gnt_ok && !special), .word(g_w),
    .dividend(aa), .divisor(ab), .done(core_done), .quotient(core_q), .remainder(core_r)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      is_rem <= 1'b0;
      word_q <= 1'b0;
      neg_q <= 1'b0;
      rsp_data <= '0;
    end else if (state == IDLE) begin
      if (gnt_ok) begin
        owner <= gnt;
        rr_ptr <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        is_rem <= g_rem;
        word_q <= g_w;
        neg_q <= g_rem ? sa : sa ^ sb;
        state <= special ? DONE : BUSY;
        if (special) rsp_data <= g_w ? sx32(sp, 1'b1) : sp;
      end
    end else if (req_kill[owner]) begin
      state <= IDLE;
    end else if (state == BUSY) begin
      if (core_done) begin
        rsp_data <= word_q ? sx32(neg_q ? -res : res, 1'b1) : (neg_q ? -res : res);
        state <= DONE;
      end
    end else if (!rsp_stall[owner]) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_pu_riscv_div_arbiter.sv
// tb_pu_riscv_div_arbiter: random and directed checks of the shared divider against an arithmetic model
module tb_pu_riscv_div_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, req_word, req_kill, rsp_stall, rsp_valid;
  logic [1:0][63:0] req_opA, req_opB;
  logic [1:0][1:0] req_func;
  logic [63:0] rsp_data;
  logic busy;
  int vectors = 0;
  int errors = 0;
  int rr_m = 0;
  always #5 clk = ~clk;
  pu_riscv_div_arbiter #(.XLEN(64), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_opA(req_opA),
    .req_opB(req_opB), .req_func(req_func), .req_word(req_word), .req_kill(req_kill),
    .rsp_stall(rsp_stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit is_special(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f, input logic w);
    if (w) return b[31:0] == 0 || (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hffff_ffff);
    return b == 0 || (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction
  // RISC-V M semantics expressed with the simulator's own division operators
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f, input logic w);
    logic [31:0] a3, b3, r3;
    logic [63:0] r;
    a3 = a[31:0];
    b3 = b[31:0];
    if (w) begin
      if (b3 == 0) r3 = f[1] ? a3 : 32'hffff_ffff;
      else if (is_special(a, b, f, w)) r3 = f[1] ? 32'h0 : a3;
      else if (!f[0]) r3 = f[1] ? $signed(a3) % $signed(b3) : $signed(a3) / $signed(b3);
      else r3 = f[1] ? a3 % b3 : a3 / b3;
      return {{32{r3[31]}}, r3};
    end
    if (b == 0) r = f[1] ? a : '1;
    else if (is_special(a, b, f, w)) r = f[1] ? 64'h0 : a;
    else if (!f[0]) r = f[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    else r = f[1] ? a % b : a / b;
    return r;
  endfunction
  function automatic int exp_grant(input logic [1:0] v, input logic [1:0] k, input int rr);
    for (int n = 0; n < 2; n++)
      if (v[(rr + n) % 2] && !k[(rr + n) % 2]) return (rr + n) % 2;
    return -1;
  endfunction
  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction
  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b, input logic [1:0] f, input logic w);
    req_opA[i] = a;
    req_opB[i] = b;
    req_func[i] = f;
    req_word[i] = w;
    req_valid[i] = 1'b1;
  endtask
  // called just after a falling edge while the divider is idle
  task automatic accept();
    int g;
    g = exp_grant(req_valid, req_kill, rr_m);
    #1;
    check("grant", 64'(req_ready), g < 0 ? 64'h0 : 64'(1) << g);
    if (g >= 0) rr_m = (g + 1) % 2;
  endtask
  task automatic finish_op(input int i, input logic [63:0] e, input int exp_lat, input int stall);
    int lat;
    rsp_stall[i] = stall > 0;
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 1;
    while (!rsp_valid[i] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("data", rsp_data, e);
    check("rsp_onehot", 64'(rsp_valid), 64'(1) << i);
    check("busy_done", 64'(busy), 64'h1);
    for (int h = 1; h <= stall; h++) begin
      @(negedge clk);
      check("held_valid", 64'(rsp_valid), 64'(1) << i);
      check("held_data", rsp_data, e);
      if (h == stall) rsp_stall[i] = 1'b0;
    end
    @(negedge clk);
    check("after_valid", 64'(rsp_valid), 64'h0);
    check("after_busy", 64'(busy), 64'h0);
  endtask
  task automatic do_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic [1:0] f, input logic w, input int stall);
    issue(i, a, b, f, w);
    accept();
    finish_op(i, ref_div(a, b, f, w), is_special(a, b, f, w) ? 1 : (w ? 33 : 65), stall);
  endtask
  initial begin
    int seen;
    logic [63:0] a, b;
    rst = 1'b1;
    req_valid = '0;
    req_kill = '0;
    rsp_stall = '0;
    req_word = '0;
    req_opA = '0;
    req_opB = '0;
    req_func = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_valid", 64'(rsp_valid), 64'h0);
    check("rst_data", rsp_data, 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    // both valid from rr_ptr=0: req0 first, req1 the cycle after req0's transfer
    issue(0, 64'd100, 64'd7, 2'd1, 1'b0);
    issue(1, -64'sd7, 64'd2, 2'd0, 1'b0);
    accept();
    finish_op(0, 64'd14, 65, 0);
    accept();
    finish_op(1, 64'hffff_ffff_ffff_fffd, 65, 0);
    do_op(0, 64'd100, 64'd7, 2'd3, 1'b0, 0);
    issue(0, 64'd9, 64'd4, 2'd1, 1'b0);
    issue(1, -64'sd7, 64'd2, 2'd2, 1'b0);
    accept();
    finish_op(1, 64'hffff_ffff_ffff_ffff, 65, 0);
    accept();
    finish_op(0, 64'd2, 65, 0);
    do_op(0, 64'd5, 64'd0, 2'd1, 1'b0, 0);
    do_op(1, 64'd5, 64'd0, 2'd3, 1'b0, 0);
    do_op(0, 64'h0000_0001_8000_0000, '1, 2'd0, 1'b1, 0);
    do_op(1, 64'd1000, 64'd3, 2'd1, 1'b0, 3);
    // kill the owner mid-divide with req1 pending
    issue(0, 64'hdead_beef_1234_5678, 64'd13, 2'd1, 1'b0);
    accept();
    @(negedge clk);
    req_valid[0] = 1'b0;
    issue(1, 64'd77, 64'd5, 2'd3, 1'b0);
    repeat (9) @(negedge clk);
    check("pending_ready", 64'(req_ready), 64'h0);
    req_kill[0] = 1'b1;
    @(negedge clk);
    req_kill[0] = 1'b0;
    check("kill_valid", 64'(rsp_valid), 64'h0);
    check("kill_busy", 64'(busy), 64'h0);
    accept();
    finish_op(1, 64'd2, 65, 0);
    // reset mid-divide abandons the op
    issue(1, 64'd123456, 64'd7, 2'd1, 1'b0);
    accept();
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    check("mid_rst_ready", 64'(req_ready), 64'h0);
    check("mid_rst_valid", 64'(rsp_valid), 64'h0);
    check("mid_rst_data", rsp_data, 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (rsp_valid != 0 || busy) seen++;
    end
    check("no_rsp_after_rst", 64'(seen), 64'h0);
    for (int n = 0; n < 40; n++) begin
      a = rnd_op();
      b = rnd_op();
      do_op(int'($urandom_range(0, 1)), a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pu_riscv_div_arbiter.md
Name: pu_riscv_div_arbiter

Overview:
- Shares one iterative radix-2 divider between NREQ execution-stage requesters (e.g. two execution lanes, or the ALU and the debug unit).
- Arbitrates round-robin, runs DIV/DIVU/REM/REMU and the RV64 word forms, and returns the result to the owning requester.
- Honours per-requester flush (kill) and writeback stall.
- Sits beside the execution units and replaces their private dividers.

Parameters:
- XLEN, 64: operand/result width (32 or 64).
- NREQ, 2: number of requesters (2..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request present.
- req_ready  out  NREQ  request accepted this cycle.
- req_opA  in  NREQ x XLEN  dividend.
- req_opB  in  NREQ x XLEN  divisor.
- req_func  in  NREQ x 2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- req_word  in  NREQ  32-bit W-form op; ignored when XLEN=32.
- req_kill  in  NREQ  flush of requester i (bu_flush/st_flush/du_flush).
- rsp_stall  in  NREQ  requester cannot take its result (wb_stall).
- rsp_valid  out  NREQ  result valid for requester i.
- rsp_data  out  XLEN  result, shared by all requesters.
- busy  out  1  divider occupied.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=0. Reset mid-operation abandons the op and emits no response.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Grant the first i at or after rr_ptr, cyclically, with req_valid[i] & !req_kill[i].
  - req_ready[i]=1 combinationally for the granted i only; req_ready is 0 in every other state.
  - On grant: latch operands, func, word, owner; rr_ptr <= (owner+1) mod NREQ.
- Special cases, decided at grant; state -> DONE directly, so rsp_valid appears the next cycle:
  - Divisor=0: quotient = all ones; remainder = dividend.
  - Signed with dividend=MIN and divisor=-1: quotient = MIN; remainder = 0.
- Otherwise state -> BUSY with cnt = W-1, where W=32 for word ops and XLEN otherwise.
- BUSY:
  - One restoring shift-subtract step per cycle on absolute values; cnt decrements.
  - At cnt=0 -> DONE.
  - rsp_valid[owner] is asserted the cycle after the last step.
  - Normal latency: acceptance in cycle 0, rsp_valid in cycle W+1.
- Signed fix-up at DONE entry:
  - Quotient negated when the operand signs differ.
  - Remainder takes the dividend's sign.
- Word ops:
  - Operate on opA[31:0] and opB[31:0], sign-extended (DIVW/REMW) or zero-extended (DIVUW/REMUW).
  - The 32-bit result is sign-extended to XLEN.
- DONE:
  - rsp_valid[owner]=1 and rsp_data is held stable while rsp_stall[owner]=1.
  - The first cycle rsp_stall[owner]=0 is the transfer cycle; next state IDLE, so the next grant follows one cycle later.
- Kill:
  - req_kill[owner] in BUSY or DONE -> IDLE next cycle; rsp_valid is deasserted and no response is produced.
  - A kill on a non-owner has no effect on the current op.
  - A killed request is never granted.
- busy=1 in BUSY and DONE.
- Only one rsp_valid bit is ever set at a time.

Decomposition:
- Package pu_riscv_verilog_pkg gains:
  - div_func_t enum (DIV, DIVU, REM, REMU).
  - div_state_t enum (IDLE, BUSY, DONE).
- Sub-module pu_riscv_div_core:
  - Unsigned iterative shift-subtract datapath with start, width select, done, quotient and remainder.
  - The arbiter owns arbitration, sign handling, special cases and the FSM.

Test Plan:
- XLEN=64, req0 DIVU 100/7 -> req_ready[0] in cycle 0, rsp_valid[0] in cycle 65, rsp_data=14; REMU -> 2.
- req1 DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVU 5/0 -> rsp_valid in cycle 1, all ones; REMU 5/0 -> 5.
- DIVW with opA=0x0000_0001_8000_0000, opB=all ones -> 0xFFFF_FFFF_8000_0000 in cycle 1.
- Both requesters valid with rr_ptr=0 -> req0 served first; req1 granted the cycle after req0's transfer. Repeat with both valid -> req1 served first.
- req_kill[0] at BUSY cycle 10 -> IDLE next cycle, rsp_valid stays 0, pending req1 granted the following cycle.
- rsp_stall[1]=1 for 3 cycles at completion -> rsp_valid[1] and rsp_data held 3 cycles, then transfer.
- rst asserted mid-BUSY -> all outputs 0 next cycle, no response.
